dct8_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational 8-point lifting forward DCT (1-D binDCT).
- Four registered stages with valid/ready handshake on both sides.
- Optional JPEG level shift and a user sideband carried with each vector.
- Sits between the 8x8 block buffer (row/column feed) and the transpose/quantiser; instantiated twice for 2-D.

---
 rtl/dct8_pipe.sv | 143 ++++++++++++++
 tb/tb_dct8_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct8_pipe.sv
// dct8_pipe
// ---------
// Pipelined 8-point lifting forward DCT (1-D binDCT). Four registered
// stages (butterfly, lifting rotation, butterfly, output lifting) with a
// valid/ready handshake on both sides. Used twice (rows, then columns) for
// the 2-D transform, between the 8x8 block buffer and the transpose/quantiser.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   s_valid / s_ready   : input handshake; s_ready depends only on the output side
//   s_data  [8*INPUT_W] : samples, x[i] = s_data[i*INPUT_W +: INPUT_W]
//   s_user  [USER_W]    : sideband, travels with its vector unchanged
//   m_valid / m_ready   : output handshake
//   m_data  [8*DATA_W]  : coefficients, y[i] = m_data[i*DATA_W +: DATA_W],
//                         lane order y0..y7 (not frequency order)
//   m_user  [USER_W]    : sideband aligned with m_data
//
// All arithmetic is DATA_W-bit two's complement and wraps; >>> is a floor shift.

module dct8_pipe #(
    parameter int INPUT_W     = 8,
    parameter int DATA_W      = 16,
    parameter int LEVEL_SHIFT = 1,
    parameter int USER_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [8*INPUT_W-1:0]  s_data,
    input  logic [USER_W-1:0]     s_user,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [8*DATA_W-1:0]   m_data,
    output logic [USER_W-1:0]     m_user
);

    typedef logic signed [DATA_W-1:0] sample_t;

    localparam sample_t SHIFT_OFS = sample_t'(2 ** (INPUT_W - 1));

    sample_t               x     [8];
    sample_t               a_d   [8];
    sample_t               b_d   [8];
    sample_t               c_d   [8];
    sample_t               y_d   [8];
    sample_t               a_q   [8];
    sample_t               b_q   [8];
    sample_t               c_q   [8];
    sample_t               y_q   [8];
    logic [3:0]            vld_q;
    logic [USER_W-1:0]     user_q [4];
    logic                  en;

    // Whole pipeline advances together; a full output register that is not
    // being taken freezes every stage, so no bubble collapsing happens.
    assign en      = !vld_q[3] || m_ready;
    assign s_ready = en;
    assign m_valid = vld_q[3];
    assign m_user  = user_q[3];

    // Input conditioning and first butterfly. With level shift the input is
    // treated as unsigned and re-centred around zero.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (LEVEL_SHIFT != 0)
                x[i] = sample_t'({{(DATA_W-INPUT_W){1'b0}}, s_data[i*INPUT_W +: INPUT_W]}) - SHIFT_OFS;
            else
                x[i] = sample_t'({{(DATA_W-INPUT_W){s_data[i*INPUT_W+INPUT_W-1]}},
                                  s_data[i*INPUT_W +: INPUT_W]});
        end
        for (int i = 0; i < 4; i++) begin
            a_d[i]     = x[i] + x[7-i];
            a_d[4+i]   = x[3-i] - x[4+i];
        end
    end

    // Lifting rotation on the odd pair; b5 deliberately uses the freshly
    // lifted b6 rather than a6.
    always_comb begin
        sample_t b6;
        b_d = a_q;
        b6     = (a_q[5] >>> 3) + (a_q[5] >>> 2) + a_q[6];
        b_d[6] = b6;
        b_d[5] = (b6 >>> 3) + (b6 >>> 1) - a_q[5];
    end

    // Second butterfly.
    always_comb begin
        c_d[0] = b_q[0] + b_q[3];
        c_d[1] = b_q[1] + b_q[2];
        c_d[2] = b_q[1] - b_q[2];
        c_d[3] = b_q[0] - b_q[3];
        c_d[4] = b_q[4] + b_q[5];
        c_d[5] = b_q[4] - b_q[5];
        c_d[6] = b_q[7] - b_q[6];
        c_d[7] = b_q[7] + b_q[6];
    end

    // Output lifting steps; y1, y3 and y6 chain on results of this same stage.
    always_comb begin
        sample_t y0, y2, y5;
        y0     = c_q[0] + c_q[1];
        y2     = ((c_q[3] >>> 3) + (c_q[3] >>> 2)) - c_q[2];
        y5     = ((c_q[6] >>> 3) + (c_q[6] >>> 2) + (c_q[6] >>> 1)) + c_q[5];
        y_d[0] = y0;
        y_d[1] = (y0 >>> 1) - c_q[1];
        y_d[2] = y2;
        y_d[3] = ((y2 >>> 3) + (y2 >>> 2)) + c_q[3];
        y_d[4] = c_q[4] - (c_q[7] >>> 3);
        y_d[5] = y5;
        y_d[6] = c_q[6] - (y5 >>> 1);
        y_d[7] = c_q[7];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            a_q    <= '{default: '0};
            b_q    <= '{default: '0};
            c_q    <= '{default: '0};
            y_q    <= '{default: '0};
            user_q <= '{default: '0};
        end else if (en) begin
            vld_q     <= {vld_q[2:0], s_valid && s_ready};
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            y_q       <= y_d;
            user_q[0] <= s_user;
            user_q[1] <= user_q[0];
            user_q[2] <= user_q[1];
            user_q[3] <= user_q[2];
        end
    end

    always_comb begin
        m_data = '0;
        for (int i = 0; i < 8; i++)
            m_data[i*DATA_W +: DATA_W] = y_q[i];
    end

endmodule

// File: tb/tb_dct8_pipe.sv
// Bench for dct8_pipe. Two instances share all inputs: one level-shifted
// (unsigned input), one without level shift (signed input). Expected results
// are pushed on a scoreboard when a vector is accepted and compared when the
// output handshake fires.

module tb_dct8_pipe;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic          s_ready0;
    logic [63:0]   s_data;
    logic [3:0]    s_user;
    logic          m_valid;
    logic          m_valid0;
    logic          m_ready;
    logic [127:0]  m_data;
    logic [127:0]  m_data0;
    logic [3:0]    m_user;
    logic [3:0]    m_user0;

    typedef struct {
        logic [127:0] d1;
        logic [127:0] d0;
        logic [3:0]   u;
        int           en;
    } exp_t;

    exp_t          sb[$];
    int            compareCount = 0;
    int            mismatchCount = 0;
    logic [127:0]  curExp1 = '0;
    logic [127:0]  curExp0 = '0;
    int            readyMode = 0;
    int            cyc = 0;
    int            stallStart = 0;
    bit            rstChecked = 0;
    bit            prevStall = 0;
    logic [127:0]  prevData = '0;
    logic [3:0]    prevUser = '0;
    int            enCnt = 0;

    dct8_pipe #(.INPUT_W(8), .DATA_W(16), .LEVEL_SHIFT(1), .USER_W(4)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_user(s_user),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user)
    );

    dct8_pipe #(.INPUT_W(8), .DATA_W(16), .LEVEL_SHIFT(0), .USER_W(4)) dut0 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data), .s_user(s_user),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_user(m_user0)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Counts, and reports any difference between observed and expected.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] packY(input int y0, input int y1, input int y2, input int y3,
                                           input int y4, input int y5, input int y6, input int y7);
        int t[8];
        logic [127:0] r;
        t = '{y0, y1, y2, y3, y4, y5, y6, y7};
        r = '0;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = t[i][15:0];
        return r;
    endfunction

    // Reference transform in plain integer arithmetic (no 16-bit wrap is
    // reachable with 8-bit inputs, so int results truncated at the end match).
    function automatic logic [127:0] model(input logic [63:0] s, input bit ls);
        int x[8], a[8], b[8], c[8], y[8];
        logic [7:0] s8;
        for (int i = 0; i < 8; i++) begin
            s8 = s[i*8 +: 8];
            x[i] = ls ? (int'(s8) - 128) : int'($signed(s8));
        end
        for (int i = 0; i < 4; i++) begin
            a[i]   = x[i] + x[7-i];
            a[4+i] = x[3-i] - x[4+i];
        end
        b = a;
        b[6] = (a[5] >>> 3) + (a[5] >>> 2) + a[6];
        b[5] = (b[6] >>> 3) + (b[6] >>> 1) - a[5];
        c[0] = b[0] + b[3];  c[1] = b[1] + b[2];
        c[2] = b[1] - b[2];  c[3] = b[0] - b[3];
        c[4] = b[4] + b[5];  c[5] = b[4] - b[5];
        c[6] = b[7] - b[6];  c[7] = b[7] + b[6];
        y[0] = c[0] + c[1];
        y[1] = (y[0] >>> 1) - c[1];
        y[2] = ((c[3] >>> 3) + (c[3] >>> 2)) - c[2];
        y[3] = ((y[2] >>> 3) + (y[2] >>> 2)) + c[3];
        y[4] = c[4] - (c[7] >>> 3);
        y[5] = ((c[6] >>> 3) + (c[6] >>> 2) + (c[6] >>> 1)) + c[5];
        y[6] = c[6] - (y[5] >>> 1);
        y[7] = c[7];
        return packY(y[0], y[1], y[2], y[3], y[4], y[5], y[6], y[7]);
    endfunction

    // Presents one vector and holds it until accepted (bounded wait).
    task automatic applyStimulus(input logic [63:0] data, input logic [3:0] user,
                                 input logic [127:0] e1, input logic [127:0] e0,
                                 input int maxCycles);
        bit acc;
        s_data  = data;
        s_user  = user;
        curExp1 = e1;
        curExp0 = e0;
        s_valid = 1;
        for (int k = 0; k < maxCycles; k++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        checkOutput("accept_timeout", 0, 1);
    endtask

    // Cycle counter and downstream ready pattern.
    initial begin
        m_ready = 1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            case (readyMode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = !(cyc >= stallStart && cyc < stallStart + 4);
                default: m_ready = 1;
            endcase
        end
    end

    // Monitor: handshake rules, output hold, scoreboard and latency in
    // advancing cycles (accept edge plus four more advances).
    initial begin
        exp_t e;
        bit   en;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                if (!rstChecked) begin
                    #1;
                    checkOutput("rst_m_valid", m_valid, 0);
                    checkOutput("rst_m_valid0", m_valid0, 0);
                    checkOutput("rst_m_data", m_data, 0);
                    checkOutput("rst_m_user", m_user, 0);
                    rstChecked = 1;
                end
                sb.delete();
                prevStall = 0;
                enCnt = 0;
            end else begin
                rstChecked = 0;
                en = !m_valid || m_ready;
                checkOutput("s_ready", s_ready, en);
                checkOutput("valid_ls0", m_valid0, m_valid);
                if (en) enCnt++;
                if (prevStall) begin
                    checkOutput("hold_data", m_data, prevData);
                    checkOutput("hold_user", m_user, prevUser);
                end
                prevStall = m_valid && !m_ready;
                prevData  = m_data;
                prevUser  = m_user;
                if (s_valid && s_ready) begin
                    e.d1 = curExp1;
                    e.d0 = curExp0;
                    e.u  = s_user;
                    e.en = enCnt;
                    sb.push_back(e);
                end
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        checkOutput("spurious_out", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("data_ls1", m_data, e.d1);
                        checkOutput("data_ls0", m_data0, e.d0);
                        checkOutput("user", m_user, e.u);
                        checkOutput("user_ls0", m_user0, e.u);
                        checkOutput("latency", enCnt - e.en, 4);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] d;
        int          start;
        rst = 1;
        s_valid = 0;
        s_data = '0;
        s_user = '0;
        repeat (3) @(posedge clk);
        #3 rst = 0;
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived results.
        readyMode = 0;
        applyStimulus({8{8'hFF}}, 4'd1, packY(1016, 0, 0, 0, 0, 0, 0, 0),
                      packY(-8, 0, 0, 0, 0, 0, 0, 0), 20);
        applyStimulus(64'h0, 4'd2, packY(-1024, 0, 0, 0, 0, 0, 0, 0),
                      packY(0, 0, 0, 0, 0, 0, 0, 0), 20);
        applyStimulus(64'h0706050403020100, 4'd3, packY(-996, 0, 0, 0, -1, 1, 0, -14),
                      packY(28, 0, 0, 0, -1, 1, 0, -14), 20);
        s_valid = 0;
        repeat (8) @(posedge clk);
        #1;

        // Back-to-back burst with a four-cycle downstream stall.
        stallStart = cyc + 5;
        readyMode = 2;
        for (int k = 0; k < 16; k++) begin
            d = {$urandom, $urandom};
            applyStimulus(d, 4'(k), model(d, 1), model(d, 0), 20);
        end
        s_valid = 0;
        repeat (12) @(posedge clk);
        #1;

        // Random traffic on both sides.
        readyMode = 1;
        start = cyc;
        while (cyc < start + 10000) begin
            if ($urandom_range(0, 3) != 0) begin
                d = {$urandom, $urandom};
                applyStimulus(d, 4'($urandom_range(0, 15)), model(d, 1), model(d, 0), 50);
            end else begin
                s_valid = 0;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 0;
        readyMode = 0;
        repeat (10) @(posedge clk);
        #1;

        // Asynchronous reset with three vectors in flight.
        for (int k = 0; k < 3; k++) begin
            d = {$urandom, $urandom};
            applyStimulus(d, 4'(k), model(d, 1), model(d, 0), 20);
        end
        s_valid = 0;
        #2 rst = 1;
        @(posedge clk);
        #3 rst = 0;
        readyMode = 1;
        repeat (6) @(posedge clk);
        #1;
        readyMode = 0;
        @(posedge clk);
        #1;
        d = {$urandom, $urandom};
        applyStimulus(d, 4'd9, model(d, 1), model(d, 0), 20);
        s_valid = 0;

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        checkOutput("drain_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
